// File: rtl/fetch_stage.sv
// fetch_stage: boots the PC from the reset vector, fetches one word per cycle
// into the IF/ID register, and applies ICU injection/override, branch redirects
// and hazard freezes.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        icu_stall,
  input  logic [15:0] icu_instruction,
  input  logic        icu_pc_load,
  input  logic [31:0] icu_pc_value,
  input  logic        hazard_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instruction,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic [31:0] ret_pc
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INSN_W = 16;
  localparam logic [INSN_W-1:0] NOP = INSN_W'(0);

  typedef enum logic [1:0] {
    BOOT_HI = 2'd0,
    BOOT_LO = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     ret_pc_d;
  logic                stall_q, stall_d;
  logic [INSN_W-1:0]   ifid_insn_d;
  logic [PC_W-1:0]     ifid_pc_d;
  logic                ifid_valid_d;
  logic [PC_W-1:0]     pc_inc_c;

  assign pc_inc_c = pc_q + PC_W'(1);

  // Next-state, fetch address and IF/ID update; RUN applies the redirect priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ret_pc_d     = ret_pc;
    stall_d      = stall_q;
    ifid_insn_d  = ifid_instruction;
    ifid_pc_d    = ifid_pc;
    ifid_valid_d = ifid_valid;
    imem_addr    = pc_q;

    unique case (state_q)
      BOOT_HI: begin
        imem_addr = PC_W'(0);
        pc_d      = {imem_data, pc_q[INSN_W-1:0]};
        state_d   = BOOT_LO;
      end
      BOOT_LO: begin
        imem_addr = PC_W'(1);
        pc_d      = {pc_q[PC_W-1:INSN_W], imem_data};
        state_d   = RUN;
      end
      RUN: begin
        stall_d = icu_stall;
        // Return address is latched once, on the first stalled cycle; the word
        // at the old pc is dropped so it is re-fetched after the ISR.
        if (icu_stall && !stall_q) begin
          ret_pc_d = branch_taken ? branch_target : pc_q;
        end

        if (icu_pc_load) begin
          pc_d         = icu_pc_value;
          ifid_insn_d  = NOP;
          ifid_pc_d    = PC_W'(0);
          ifid_valid_d = 1'b0;
        end else if (branch_taken) begin
          pc_d = branch_target;
          if (icu_stall) begin
            ifid_insn_d  = icu_instruction;
            ifid_pc_d    = ret_pc_d;
            ifid_valid_d = 1'b1;
          end else begin
            ifid_insn_d  = NOP;
            ifid_pc_d    = PC_W'(0);
            ifid_valid_d = 1'b0;
          end
        end else if (icu_stall) begin
          ifid_insn_d  = icu_instruction;
          ifid_pc_d    = ret_pc_d;
          ifid_valid_d = 1'b1;
        end else if (hazard_stall) begin
          pc_d = pc_q;
        end else begin
          pc_d         = pc_inc_c;
          ifid_insn_d  = imem_data;
          ifid_pc_d    = pc_inc_c;
          ifid_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = BOOT_HI;
      end
    endcase
  end

  // State and pipeline registers; enable=0 freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= BOOT_HI;
      pc_q             <= PC_W'(0);
      ret_pc           <= PC_W'(0);
      stall_q          <= 1'b0;
      ifid_instruction <= NOP;
      ifid_pc          <= PC_W'(0);
      ifid_valid       <= 1'b0;
    end else if (enable) begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      ret_pc           <= ret_pc_d;
      stall_q          <= stall_d;
      ifid_instruction <= ifid_insn_d;
      ifid_pc          <= ifid_pc_d;
      ifid_valid       <= ifid_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed tests for boot, fetch, ICU injection, branch,
// hazard, enable, PC wrap and mid-interrupt reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        icu_stall;
  logic [15:0] icu_instruction;
  logic        icu_pc_load;
  logic [31:0] icu_pc_value;
  logic        hazard_stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instruction;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [31:0] ret_pc;

  logic [15:0] mem [0:255];
  int n_cmp;
  int n_err;

  assign imem_data = mem[imem_addr[7:0]];

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .icu_stall        (icu_stall),
    .icu_instruction  (icu_instruction),
    .icu_pc_load      (icu_pc_load),
    .icu_pc_value     (icu_pc_value),
    .hazard_stall     (hazard_stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_data        (imem_data),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .ret_pc           (ret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an ICU PC load for one edge.
  task automatic load_pc(input logic [31:0] v);
    icu_pc_load  = 1'b1;
    icu_pc_value = v;
    step();
    icu_pc_load  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp %h", imem_addr, 32'h0); end
    n_cmp++; if (ifid_instruction !== 16'h0) begin n_err++; $display("FAIL rst_insn: got %h exp %h", ifid_instruction, 16'h0); end
    n_cmp++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL rst_ifid_pc: got %h exp %h", ifid_pc, 32'h0); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", ifid_valid); end
    n_cmp++; if (ret_pc !== 32'h0) begin n_err++; $display("FAIL rst_ret_pc: got %h exp %h", ret_pc, 32'h0); end
  endtask

  task automatic test_boot();
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL boot_hi_addr: got %h exp %h", imem_addr, 32'h0); end
    step();
    n_cmp++; if (imem_addr !== 32'h1) begin n_err++; $display("FAIL boot_lo_addr: got %h exp %h", imem_addr, 32'h1); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b exp 0", ifid_valid); end
    step();
    n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL boot_vec: got %h exp %h", imem_addr, 32'h10); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid2: got %b exp 0", ifid_valid); end
    step();
    n_cmp++; if (ifid_instruction !== 16'h1111) begin n_err++; $display("FAIL fetch1_insn: got %h exp %h", ifid_instruction, 16'h1111); end
    n_cmp++; if (ifid_pc !== 32'h11) begin n_err++; $display("FAIL fetch1_pc: got %h exp %h", ifid_pc, 32'h11); end
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL fetch1_valid: got %b exp 1", ifid_valid); end
    n_cmp++; if (imem_addr !== 32'h11) begin n_err++; $display("FAIL fetch1_addr: got %h exp %h", imem_addr, 32'h11); end
    step();
    n_cmp++; if (ifid_instruction !== 16'h2222) begin n_err++; $display("FAIL fetch2_insn: got %h exp %h", ifid_instruction, 16'h2222); end
    n_cmp++; if (ifid_pc !== 32'h12) begin n_err++; $display("FAIL fetch2_pc: got %h exp %h", ifid_pc, 32'h12); end
  endtask

  task automatic test_interrupt();
    logic [15:0] w [0:4];
    w[0] = 16'h0000; w[1] = 16'h0000; w[2] = 16'h600A; w[3] = 16'h6008; w[4] = 16'h6009;
    load_pc(32'h20);
    n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL int_load_addr: got %h exp %h", imem_addr, 32'h20); end
    for (int i = 0; i < 5; i++) begin
      icu_stall       = 1'b1;
      icu_instruction = w[i];
      step();
      n_cmp++; if (ifid_instruction !== w[i]) begin n_err++; $display("FAIL int_insn%0d: got %h exp %h", i, ifid_instruction, w[i]); end
      n_cmp++; if (ifid_pc !== 32'h20) begin n_err++; $display("FAIL int_ifid_pc%0d: got %h exp %h", i, ifid_pc, 32'h20); end
      n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL int_valid%0d: got %b exp 1", i, ifid_valid); end
      n_cmp++; if (ret_pc !== 32'h20) begin n_err++; $display("FAIL int_ret_pc%0d: got %h exp %h", i, ret_pc, 32'h20); end
      n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL int_pc_hold%0d: got %h exp %h", i, imem_addr, 32'h20); end
    end
    icu_instruction = 16'h0000;
    load_pc(32'h0);
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL int_override_addr: got %h exp %h", imem_addr, 32'h0); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL int_override_valid: got %b exp 0", ifid_valid); end
    n_cmp++; if (ifid_instruction !== 16'h0) begin n_err++; $display("FAIL int_override_insn: got %h exp %h", ifid_instruction, 16'h0); end
    n_cmp++; if (ret_pc !== 32'h20) begin n_err++; $display("FAIL int_override_ret: got %h exp %h", ret_pc, 32'h20); end
    icu_stall = 1'b0;
    step();
    n_cmp++; if (ifid_instruction !== 16'h0000) begin n_err++; $display("FAIL int_after_insn: got %h exp %h", ifid_instruction, 16'h0000); end
    n_cmp++; if (ifid_pc !== 32'h1) begin n_err++; $display("FAIL int_after_pc: got %h exp %h", ifid_pc, 32'h1); end
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL int_after_valid: got %b exp 1", ifid_valid); end
  endtask

  task automatic test_branch();
    load_pc(32'h30);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken  = 1'b0;
    n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL br_addr: got %h exp %h", imem_addr, 32'h40); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL br_bubble: got %b exp 0", ifid_valid); end
    step();
    n_cmp++; if (ifid_instruction !== 16'hA040) begin n_err++; $display("FAIL br_insn: got %h exp %h", ifid_instruction, 16'hA040); end
    n_cmp++; if (ifid_pc !== 32'h41) begin n_err++; $display("FAIL br_pc: got %h exp %h", ifid_pc, 32'h41); end
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL br_valid: got %b exp 1", ifid_valid); end
  endtask

  task automatic test_branch_interrupt();
    load_pc(32'h48);
    icu_stall       = 1'b1;
    icu_instruction = 16'h600A;
    branch_taken    = 1'b1;
    branch_target   = 32'h50;
    step();
    icu_stall     = 1'b0;
    branch_taken  = 1'b0;
    n_cmp++; if (ret_pc !== 32'h50) begin n_err++; $display("FAIL brint_ret: got %h exp %h", ret_pc, 32'h50); end
    n_cmp++; if (imem_addr !== 32'h50) begin n_err++; $display("FAIL brint_addr: got %h exp %h", imem_addr, 32'h50); end
    n_cmp++; if (ifid_instruction !== 16'h600A) begin n_err++; $display("FAIL brint_insn: got %h exp %h", ifid_instruction, 16'h600A); end
    n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL brint_valid: got %b exp 1", ifid_valid); end
    n_cmp++; if (ifid_pc !== 32'h50) begin n_err++; $display("FAIL brint_ifid_pc: got %h exp %h", ifid_pc, 32'h50); end
    step();
    n_cmp++; if (ifid_instruction !== 16'hA050) begin n_err++; $display("FAIL brint_next_insn: got %h exp %h", ifid_instruction, 16'hA050); end
    n_cmp++; if (imem_addr !== 32'h51) begin n_err++; $display("FAIL brint_next_addr: got %h exp %h", imem_addr, 32'h51); end
  endtask

  task automatic test_hazard();
    hazard_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (imem_addr !== 32'h51) begin n_err++; $display("FAIL hz_addr%0d: got %h exp %h", i, imem_addr, 32'h51); end
      n_cmp++; if (ifid_instruction !== 16'hA050) begin n_err++; $display("FAIL hz_insn%0d: got %h exp %h", i, ifid_instruction, 16'hA050); end
      n_cmp++; if (ifid_pc !== 32'h51) begin n_err++; $display("FAIL hz_pc%0d: got %h exp %h", i, ifid_pc, 32'h51); end
      n_cmp++; if (ifid_valid !== 1'b1) begin n_err++; $display("FAIL hz_valid%0d: got %b exp 1", i, ifid_valid); end
    end
    hazard_stall = 1'b0;
    step();
    n_cmp++; if (ifid_instruction !== 16'hA051) begin n_err++; $display("FAIL hz_resume_insn: got %h exp %h", ifid_instruction, 16'hA051); end
    n_cmp++; if (ifid_pc !== 32'h52) begin n_err++; $display("FAIL hz_resume_pc: got %h exp %h", ifid_pc, 32'h52); end
  endtask

  task automatic test_wrap();
    load_pc(32'hFFFF_FFFF);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_load: got %h exp %h", imem_addr, 32'hFFFF_FFFF); end
    step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h exp %h", imem_addr, 32'h0); end
    n_cmp++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL wrap_ifid_pc: got %h exp %h", ifid_pc, 32'h0); end
    n_cmp++; if (ifid_instruction !== 16'hA0FF) begin n_err++; $display("FAIL wrap_insn: got %h exp %h", ifid_instruction, 16'hA0FF); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    step();
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL en_run_addr: got %h exp %h", imem_addr, 32'h0); end
    n_cmp++; if (ifid_instruction !== 16'hA0FF) begin n_err++; $display("FAIL en_run_insn: got %h exp %h", ifid_instruction, 16'hA0FF); end
    enable = 1'b1;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
    step();
    n_cmp++; if (imem_addr !== 32'h1) begin n_err++; $display("FAIL en_boot_lo: got %h exp %h", imem_addr, 32'h1); end
    enable = 1'b0;
    step();
    step();
    n_cmp++; if (imem_addr !== 32'h1) begin n_err++; $display("FAIL en_boot_hold: got %h exp %h", imem_addr, 32'h1); end
    enable = 1'b1;
    step();
    n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL en_boot_resume: got %h exp %h", imem_addr, 32'h10); end
  endtask

  task automatic test_reset_mid_interrupt();
    load_pc(32'h20);
    icu_stall = 1'b1;
    icu_instruction = 16'h0000; step();
    icu_instruction = 16'h600A; step();
    icu_instruction = 16'h6008; step();
    n_cmp++; if (ifid_instruction !== 16'h6008) begin n_err++; $display("FAIL rmi_pre_insn: got %h exp %h", ifid_instruction, 16'h6008); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (ifid_instruction !== 16'h0) begin n_err++; $display("FAIL rmi_insn: got %h exp %h", ifid_instruction, 16'h0); end
    n_cmp++; if (ifid_valid !== 1'b0) begin n_err++; $display("FAIL rmi_valid: got %b exp 0", ifid_valid); end
    n_cmp++; if (ret_pc !== 32'h0) begin n_err++; $display("FAIL rmi_ret: got %h exp %h", ret_pc, 32'h0); end
    n_cmp++; if (ifid_pc !== 32'h0) begin n_err++; $display("FAIL rmi_ifid_pc: got %h exp %h", ifid_pc, 32'h0); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmi_addr: got %h exp %h", imem_addr, 32'h0); end
    icu_stall = 1'b0;
    icu_instruction = 16'h0000;
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rmi_boot0: got %h exp %h", imem_addr, 32'h0); end
    step();
    n_cmp++; if (imem_addr !== 32'h1) begin n_err++; $display("FAIL rmi_boot1: got %h exp %h", imem_addr, 32'h1); end
    step();
    n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL rmi_boot_vec: got %h exp %h", imem_addr, 32'h10); end
    step();
    n_cmp++; if (ifid_instruction !== 16'h1111) begin n_err++; $display("FAIL rmi_fetch: got %h exp %h", ifid_instruction, 16'h1111); end
    n_cmp++; if (ifid_pc !== 32'h11) begin n_err++; $display("FAIL rmi_fetch_pc: got %h exp %h", ifid_pc, 32'h11); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
    mem[0]    = 16'h0000;
    mem[1]    = 16'h0010;
    mem[16]   = 16'h1111;
    mem[17]   = 16'h2222;
    reset           = 1'b1;
    enable          = 1'b1;
    icu_stall       = 1'b0;
    icu_instruction = 16'h0000;
    icu_pc_load     = 1'b0;
    icu_pc_value    = 32'h0;
    hazard_stall    = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'h0;

    test_reset();
    test_boot();
    test_interrupt();
    test_branch();
    test_branch_interrupt();
    test_hazard();
    test_wrap();
    test_enable();
    test_reset_mid_interrupt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline, directly downstream of the interrupt control unit (ICU). It owns the 32-bit PC and the IF/ID pipeline register. It boots the PC from the reset vector in instruction memory and fetches one 16-bit word per cycle. While the ICU stalls the front end, it substitutes the ICU's injected instructions (NOP / PUSH CCR / PUSH PCL / PUSH PCH) for fetched ones, and captures the return PC those pushes store. It also applies the ICU's PC override, branch redirects and hazard freezes.

## Interface
- No parameters. Widths are fixed: PC 32 bits, instruction word 16 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  global advance enable; 0 freezes every register, FSM included.
- icu_stall  in  1  ICU stall; 1 = inject icu_instruction and hold the PC.
- icu_instruction  in  16  instruction injected by the ICU (0x0000 = NOP).
- icu_pc_load  in  1  one-cycle strobe from the ICU PC_CHANGE state; loads icu_pc_value into the PC.
- icu_pc_value  in  32  new PC; sampled only when icu_pc_load=1.
- hazard_stall  in  1  decode hazard; freezes the PC and IF/ID.
- branch_taken  in  1  redirect request from execute.
- branch_target  in  32  redirect address.
- imem_addr  out  32  combinational instruction-memory read address.
- imem_data  in  16  combinational instruction-memory read data for imem_addr.
- ifid_instruction  out  16  registered instruction for decode.
- ifid_pc  out  32  registered PC+1 of that instruction (injected: ret_pc).
- ifid_valid  out  1  1 = ifid_instruction is a real or injected instruction; 0 = bubble.
- ret_pc  out  32  return address for PUSH PCL/PCH; stable for the whole interrupt sequence.

## Operation
- FSM states:
  - BOOT_HI: imem_addr=0; pc[31:16] <= imem_data; go to BOOT_LO.
  - BOOT_LO: imem_addr=1; pc[15:0] <= imem_data; go to RUN.
  - RUN: imem_addr=pc.
  - Boot states ignore every input except enable and reset. IF/ID stays NOP/invalid during boot.
- RUN per-edge priority (first match wins):
  1. icu_pc_load: pc <= icu_pc_value; IF/ID <= NOP, valid 0.
  2. branch_taken: pc <= branch_target; IF/ID <= icu_instruction with valid 1 if icu_stall=1, else NOP with valid 0.
  3. icu_stall: pc holds; ifid_instruction <= icu_instruction, ifid_pc <= ret_pc (new value), valid 1.
  4. hazard_stall: pc and IF/ID hold.
  5. Normal: ifid_instruction <= imem_data, ifid_pc <= pc+1, valid 1; pc <= pc+1, modulo 2^32 (0xFFFFFFFF -> 0).
- ret_pc capture:
  - An internal stall_q register holds the previous icu_stall.
  - On a rising icu_stall (icu_stall=1, stall_q=0), ret_pc <= branch_target if branch_taken=1, else pc.
  - ret_pc holds otherwise. The instruction at the old pc is discarded, not executed, so it is re-fetched after the ISR returns.
- The top level guarantees hazard_stall=0 whenever icu_stall=1. The block still gives icu_stall priority.
- enable=0 holds all registers, including stall_q. imem_addr still follows the state and PC.

## Timing
- Reset values:
  - state BOOT_HI, pc 0, ret_pc 0, stall_q 0.
  - ifid_instruction 0x0000, ifid_pc 0, ifid_valid 0.
  - imem_addr 0 (combinational from BOOT_HI).
- Boot takes 2 cycles after reset deasserts. The first RUN fetch is registered into IF/ID at the 3rd rising edge.
- Fetch latency: 1 cycle, from imem_addr presentation to ifid_instruction.
- An injected instruction appears on ifid_instruction 1 edge after the ICU presents it.
- An icu_pc_load takes effect at the next edge. The instruction at icu_pc_value reaches IF/ID one edge later.
- A branch costs 1 bubble (valid 0) plus whatever is already downstream.
- Reset asserted mid-interrupt or mid-boot clears everything at once, and boot restarts from BOOT_HI.

## Test plan
- Boot and fetch: M[0]=0x0000, M[1]=0x0010, M[0x10..]=0x1111,0x2222; release reset -> imem_addr 0,1,0x10,0x11. At the 3rd edge, ifid_instruction=0x1111, ifid_pc=0x11, valid 1.
- Interrupt: pc=0x20, then the ICU presents NOP, NOP, 0x600A, 0x6008, 0x6009 with icu_stall=1, then icu_pc_load with value 0 -> ret_pc=0x20 throughout, ifid_pc=0x20 for injected words, IF/ID follows the same five words one cycle later, pc holds at 0x20. After the load, pc=0 and IF/ID is NOP/invalid; the next fetch is from address 0.
- Branch: branch_taken=1, target 0x40, with pc=0x30 -> next edge pc=0x40 and ifid_valid=0; the following edge gives ifid_instruction=M[0x40], ifid_pc=0x41.
- Interrupt rising with a simultaneous branch to 0x50 -> ret_pc=0x50, pc=0x50, IF/ID holds the injected word.
- Hazard and enable: hazard_stall=1 for 2 cycles -> pc, ifid_* unchanged. enable=0 during BOOT_LO -> state held. PC wrap: pc=0xFFFFFFFF -> next pc=0, ifid_pc=0.
- Reset mid-interrupt, during the PUSH PCL injection -> all outputs at reset values immediately; boot restarts from imem_addr 0.
